// File: rtl/bsg_manycore_eva_to_npa_pipe.sv
// Two-stage EVA->NPA translator: S1 captures the request and its address class,
// S2 holds the translated NPA. Tile-group shape, DRAM mode and DMEM base are runtime registers.
module bsg_manycore_eva_to_npa_pipe #(
  parameter int unsigned x_cord_width_p               = 6,
  parameter int unsigned y_cord_width_p               = 6,
  parameter int unsigned addr_width_p                 = 28,
  parameter int unsigned num_tiles_x_p                = 16,
  parameter int unsigned num_tiles_y_p                = 8,
  parameter int unsigned vcache_block_size_in_words_p = 8,
  parameter int unsigned vcache_size_p                = 4096,
  parameter int unsigned tag_width_p                  = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [31:0]               eva_i,
  input  logic [tag_width_p-1:0]    tag_i,
  input  logic [x_cord_width_p-1:0] tgo_x_i,
  input  logic [y_cord_width_p-1:0] tgo_y_i,

  input  logic                      cfg_v_i,
  output logic                      cfg_ready_o,
  input  logic [2:0]                cfg_lg_tg_x_i,
  input  logic [2:0]                cfg_lg_tg_y_i,
  input  logic                      cfg_dram_enable_i,
  input  logic [15:0]               cfg_dmem_base_i,

  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [x_cord_width_p-1:0] x_cord_o,
  output logic [y_cord_width_p-1:0] y_cord_o,
  output logic [addr_width_p-1:0]   epa_o,
  output logic [tag_width_p-1:0]    tag_o,
  output logic                      invalid_o,
  output logic [15:0]               invalid_count_o
);

  localparam int unsigned lg_blk_lp   = $clog2(vcache_block_size_in_words_p);
  localparam int unsigned lg_nx_lp    = $clog2(num_tiles_x_p);
  localparam int unsigned lg_bank_lp  = lg_nx_lp + 1;
  localparam int unsigned lg_vc_lp    = $clog2(vcache_size_p);
  localparam int unsigned dram_y_lp   = num_tiles_y_p + 1;
  localparam int unsigned word_w_lp   = 29;
  localparam logic [31:0] blk_mask_lp = 32'(vcache_block_size_in_words_p - 1);
  localparam logic [31:0] vc_mask_lp  = 32'(vcache_size_p - 1);

  typedef enum logic [2:0] {
    e_cls_invalid,
    e_cls_dram,
    e_cls_global,
    e_cls_tg,
    e_cls_shared
  } eva_class_e;

  // Byte-offset bits of the EVA carry no information for word translation.
  logic unused_eva_bits;
  assign unused_eva_bits = ^eva_i[1:0];

  eva_class_e                in_class;
  eva_class_e                s1_class;
  logic                      s1_v;
  logic [word_w_lp-1:0]      s1_word;   // eva[30:2]
  logic [tag_width_p-1:0]    s1_tag;
  logic [x_cord_width_p-1:0] s1_tgo_x;
  logic [y_cord_width_p-1:0] s1_tgo_y;

  logic [2:0]                cfg_lg_tg_x_r;
  logic [2:0]                cfg_lg_tg_y_r;
  logic                      cfg_dram_enable_r;
  logic [15:0]               cfg_dmem_base_r;

  logic                      s2_en;
  logic                      cfg_we;

  logic [x_cord_width_p-1:0] tr_x;
  logic [y_cord_width_p-1:0] tr_y;
  logic [addr_width_p-1:0]   tr_epa;
  logic                      tr_invalid;

  logic [3:0]                sh_h;
  logic [31:0]               sh_w;
  logic [31:0]               sh_s;
  logic [31:0]               sh_mask_x;
  logic [31:0]               sh_mask_y;
  logic [31:0]               sh_local;
  logic [lg_bank_lp-1:0]     dram_bank;
  logic [31:0]               dram_word;

  assign s2_en       = ~v_o | yumi_i;
  assign ready_o     = ~s1_v | s2_en;
  assign cfg_ready_o = ~v_i & ~s1_v & ~v_o;
  assign cfg_we      = cfg_v_i & cfg_ready_o;

  // Address class, highest priority first.
  always_comb begin
    in_class = e_cls_invalid;
    if (eva_i[31])                   in_class = e_cls_dram;
    else if (eva_i[30])              in_class = e_cls_global;
    else if (eva_i[29])              in_class = e_cls_tg;
    else if (eva_i[28:27] == 2'b01)  in_class = e_cls_shared;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cfg_lg_tg_x_r     <= 3'd2;
      cfg_lg_tg_y_r     <= 3'd2;
      cfg_dram_enable_r <= 1'b1;
      cfg_dmem_base_r   <= 16'h0400;
    end else if (cfg_we) begin
      cfg_lg_tg_x_r     <= cfg_lg_tg_x_i;
      cfg_lg_tg_y_r     <= cfg_lg_tg_y_i;
      cfg_dram_enable_r <= cfg_dram_enable_i;
      cfg_dmem_base_r   <= cfg_dmem_base_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v     <= 1'b0;
      s1_word  <= '0;
      s1_tag   <= '0;
      s1_tgo_x <= '0;
      s1_tgo_y <= '0;
      s1_class <= e_cls_invalid;
    end else if (ready_o) begin
      s1_v <= v_i;
      if (v_i) begin
        s1_word  <= eva_i[30:2];
        s1_tag   <= tag_i;
        s1_tgo_x <= tgo_x_i;
        s1_tgo_y <= tgo_y_i;
        s1_class <= in_class;
      end
    end
  end

  // Translation of the S1 request into an NPA.
  always_comb begin
    sh_h      = s1_word[24:21];
    sh_w      = 32'(s1_word[20:0]);
    sh_s      = sh_w >> sh_h;
    sh_mask_x = (32'd1 << cfg_lg_tg_x_r) - 32'd1;
    sh_mask_y = (32'd1 << cfg_lg_tg_y_r) - 32'd1;
    sh_local  = ((sh_w >> (32'(sh_h) + 32'(cfg_lg_tg_x_r) + 32'(cfg_lg_tg_y_r))) << sh_h)
              | (sh_w & ((32'd1 << sh_h) - 32'd1));
    dram_bank = s1_word[lg_blk_lp +: lg_bank_lp];
    dram_word = ((32'(s1_word) >> (lg_blk_lp + lg_bank_lp)) << lg_blk_lp)
              | (32'(s1_word) & blk_mask_lp);

    tr_x       = '0;
    tr_y       = '0;
    tr_epa     = '0;
    tr_invalid = 1'b0;

    case (s1_class)
      e_cls_global: begin
        tr_x   = x_cord_width_p'(s1_word[21:16]);
        tr_y   = y_cord_width_p'(s1_word[27:22]);
        tr_epa = addr_width_p'(s1_word[15:0]);
      end
      e_cls_tg: begin
        tr_x   = s1_tgo_x + x_cord_width_p'(s1_word[21:16]);
        tr_y   = s1_tgo_y + y_cord_width_p'(s1_word[26:22]);
        tr_epa = addr_width_p'(s1_word[15:0]);
      end
      e_cls_shared: begin
        tr_x   = s1_tgo_x + x_cord_width_p'(sh_s & sh_mask_x);
        tr_y   = s1_tgo_y + y_cord_width_p'((sh_s >> cfg_lg_tg_x_r) & sh_mask_y);
        tr_epa = addr_width_p'(32'(cfg_dmem_base_r) + sh_local);
      end
      e_cls_dram: begin
        if (cfg_dram_enable_r) begin
          tr_x   = x_cord_width_p'(dram_bank[lg_nx_lp-1:0]);
          tr_y   = dram_bank[lg_bank_lp-1] ? y_cord_width_p'(dram_y_lp) : '0;
          tr_epa = addr_width_p'(dram_word) & {1'b0, {(addr_width_p-1){1'b1}}};
        end else if (s1_word[28]) begin
          tr_x   = '0;
          tr_y   = y_cord_width_p'(1);
          tr_epa = {1'b1, s1_word[addr_width_p-2:0]};
        end else begin
          tr_x   = s1_word[lg_vc_lp +: x_cord_width_p];
          tr_y   = s1_word[lg_vc_lp + x_cord_width_p] ? y_cord_width_p'(dram_y_lp) : '0;
          tr_epa = addr_width_p'(32'(s1_word) & vc_mask_lp);
        end
      end
      default: tr_invalid = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_o       <= 1'b0;
      x_cord_o  <= '0;
      y_cord_o  <= '0;
      epa_o     <= '0;
      tag_o     <= '0;
      invalid_o <= 1'b0;
    end else if (s2_en) begin
      v_o <= s1_v;
      if (s1_v) begin
        x_cord_o  <= tr_x;
        y_cord_o  <= tr_y;
        epa_o     <= tr_epa;
        tag_o     <= s1_tag;
        invalid_o <= tr_invalid;
      end
    end
  end

  // Saturating count of invalid responses actually handed off.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      invalid_count_o <= '0;
    end else if (v_o & yumi_i & invalid_o & (invalid_count_o != 16'hFFFF)) begin
      invalid_count_o <= invalid_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_eva_to_npa_pipe.sv
// Directed bench for bsg_manycore_eva_to_npa_pipe: one task per scenario, hand-computed expectations.
module tb_bsg_manycore_eva_to_npa_pipe;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        v_i, ready_o;
  logic [31:0] eva_i;
  logic [3:0]  tag_i;
  logic [5:0]  tgo_x_i, tgo_y_i;
  logic        cfg_v_i, cfg_ready_o;
  logic [2:0]  cfg_lg_tg_x_i, cfg_lg_tg_y_i;
  logic        cfg_dram_enable_i;
  logic [15:0] cfg_dmem_base_i;
  logic        v_o, yumi_i;
  logic [5:0]  x_cord_o, y_cord_o;
  logic [27:0] epa_o;
  logic [3:0]  tag_o;
  logic        invalid_o;
  logic [15:0] invalid_count_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [5:0]  r_x, r_y;
  logic [27:0] r_epa;
  logic [3:0]  r_tag;
  logic        r_inv;
  int          r_lat;

  always #5 clk = ~clk;

  bsg_manycore_eva_to_npa_pipe dut (
    .clk_i(clk), .reset_i(reset_i),
    .v_i(v_i), .ready_o(ready_o), .eva_i(eva_i), .tag_i(tag_i),
    .tgo_x_i(tgo_x_i), .tgo_y_i(tgo_y_i),
    .cfg_v_i(cfg_v_i), .cfg_ready_o(cfg_ready_o),
    .cfg_lg_tg_x_i(cfg_lg_tg_x_i), .cfg_lg_tg_y_i(cfg_lg_tg_y_i),
    .cfg_dram_enable_i(cfg_dram_enable_i), .cfg_dmem_base_i(cfg_dmem_base_i),
    .v_o(v_o), .yumi_i(yumi_i), .x_cord_o(x_cord_o), .y_cord_o(y_cord_o),
    .epa_o(epa_o), .tag_o(tag_o), .invalid_o(invalid_o), .invalid_count_o(invalid_count_o)
  );

  // Drive one request into an empty pipe and capture its response and latency.
  task automatic xact(input logic [31:0] eva, input logic [3:0] tag,
                      input logic [5:0] tx, input logic [5:0] ty);
    int w = 0;
    r_lat = -1; r_x = '0; r_y = '0; r_epa = '0; r_tag = '0; r_inv = 1'b0;
    @(negedge clk);
    v_i = 1'b1; eva_i = eva; tag_i = tag; tgo_x_i = tx; tgo_y_i = ty; yumi_i = 1'b1;
    while (!ready_o && w < 20) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    v_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (v_o) begin
        r_x = x_cord_o; r_y = y_cord_o; r_epa = epa_o; r_tag = tag_o; r_inv = invalid_o;
        r_lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic write_cfg(input logic [2:0] lx, input logic [2:0] ly,
                           input logic en, input logic [15:0] base);
    int w = 0;
    @(negedge clk);
    cfg_v_i = 1'b1; cfg_lg_tg_x_i = lx; cfg_lg_tg_y_i = ly;
    cfg_dram_enable_i = en; cfg_dmem_base_i = base;
    while (!cfg_ready_o && w < 20) begin @(negedge clk); w++; end
    if (!cfg_ready_o) begin
      tests_run++; tests_failed++;
      $display("FAIL cfg_timeout: cfg_ready_o=%0d after %0d cycles, expected 1", cfg_ready_o, w);
    end
    @(posedge clk);
    #1 cfg_v_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({v_o, x_cord_o, y_cord_o, epa_o, tag_o, invalid_o} !== '0 || invalid_count_o !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%0d x=%0d y=%0d epa=%h tag=%0d inv=%0d cnt=%0d, expected all 0",
               v_o, x_cord_o, y_cord_o, epa_o, tag_o, invalid_o, invalid_count_o);
    end
    reset_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ready_o !== 1'b1 || cfg_ready_o !== 1'b1 || v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: got ready=%0d cfg_ready=%0d v_o=%0d, expected 1 1 0", ready_o, cfg_ready_o, v_o);
    end
  endtask

  task automatic test_global();
    logic [31:0] ev [2] = '{32'h4404_0010, 32'h7FFF_FFFC};
    logic [40:0] ex [2] = '{{1'b0, 6'd1, 6'd4, 28'h4}, {1'b0, 6'd63, 6'd63, 28'hFFFF}};
    for (int i = 0; i < 2; i++) begin
      xact(ev[i], 4'(i + 5), 6'd7, 6'd9);
      tests_run++;
      if ({r_inv, r_x, r_y, r_epa} !== ex[i] || r_tag !== 4'(i + 5) || r_lat != 2) begin
        tests_failed++;
        $display("FAIL global[%0d]: got inv/x/y/epa=%h tag=%0d lat=%0d, expected %h tag=%0d lat=2",
                 i, {r_inv, r_x, r_y, r_epa}, r_tag, r_lat, ex[i], i + 5);
      end
    end
  endtask

  task automatic test_tg();
    logic [31:0] ev [2] = '{32'h2200_0008, 32'h23F0_48D0};
    logic [5:0]  tx [2] = '{6'd3, 6'd5};
    logic [5:0]  ty [2] = '{6'd62, 6'd2};
    logic [40:0] ex [2] = '{{1'b0, 6'd3, 6'd0, 28'h2}, {1'b0, 6'd1, 6'd5, 28'h1234}};
    for (int i = 0; i < 2; i++) begin
      xact(ev[i], 4'(i + 1), tx[i], ty[i]);
      tests_run++;
      if ({r_inv, r_x, r_y, r_epa} !== ex[i] || r_tag !== 4'(i + 1) || r_lat != 2) begin
        tests_failed++;
        $display("FAIL tg[%0d]: got inv/x/y/epa=%h tag=%0d lat=%0d, expected %h tag=%0d lat=2",
                 i, {r_inv, r_x, r_y, r_epa}, r_tag, r_lat, ex[i], i + 1);
      end
    end
  endtask

  task automatic test_shared_default();
    logic [31:0] ev [2] = '{32'h0800_0014, 32'h0880_0014};
    logic [40:0] ex [2] = '{{1'b0, 6'd1, 6'd2, 28'h400}, {1'b0, 6'd2, 6'd1, 28'h401}};
    for (int i = 0; i < 2; i++) begin
      xact(ev[i], 4'(i + 9), 6'd0, 6'd1);
      tests_run++;
      if ({r_inv, r_x, r_y, r_epa} !== ex[i] || r_tag !== 4'(i + 9) || r_lat != 2) begin
        tests_failed++;
        $display("FAIL shared_default[%0d]: got inv/x/y/epa=%h tag=%0d lat=%0d, expected %h tag=%0d lat=2",
                 i, {r_inv, r_x, r_y, r_epa}, r_tag, r_lat, ex[i], i + 9);
      end
    end
  endtask

  task automatic test_dram_striped();
    logic [31:0] ev [3] = '{32'h8000_0020, 32'h8000_0200, 32'h8005_5674};
    logic [40:0] ex [3] = '{{1'b0, 6'd1, 6'd0, 28'h0}, {1'b0, 6'd0, 6'd9, 28'h0},
                            {1'b0, 6'd3, 6'd9, 28'hAAD}};
    for (int i = 0; i < 3; i++) begin
      xact(ev[i], 4'(i + 2), 6'd11, 6'd12);
      tests_run++;
      if ({r_inv, r_x, r_y, r_epa} !== ex[i] || r_tag !== 4'(i + 2)) begin
        tests_failed++;
        $display("FAIL dram_striped[%0d]: got inv/x/y/epa=%h tag=%0d, expected %h tag=%0d",
                 i, {r_inv, r_x, r_y, r_epa}, r_tag, ex[i], i + 2);
      end
    end
  endtask

  task automatic test_shared_cfg();
    write_cfg(3'd3, 3'd1, 1'b1, 16'h2000);
    xact(32'h0900_07B4, 4'd7, 6'd10, 6'd20);
    tests_run++;
    if ({r_inv, r_x, r_y, r_epa} !== {1'b0, 6'd13, 6'd21, 28'h201D}) begin
      tests_failed++;
      $display("FAIL shared_cfg: got inv/x/y/epa=%0d/%0d/%0d/%h, expected 0/13/21/201d", r_inv, r_x, r_y, r_epa);
    end
  endtask

  task automatic test_dram_block();
    logic [31:0] ev [2] = '{32'hC000_0010, 32'h8011_400C};
    logic [40:0] ex [2] = '{{1'b0, 6'd0, 6'd1, 28'h800_0004}, {1'b0, 6'd5, 6'd9, 28'h3}};
    write_cfg(3'd3, 3'd1, 1'b0, 16'h2000);
    for (int i = 0; i < 2; i++) begin
      xact(ev[i], 4'(i + 3), 6'd0, 6'd0);
      tests_run++;
      if ({r_inv, r_x, r_y, r_epa} !== ex[i]) begin
        tests_failed++;
        $display("FAIL dram_block[%0d]: got inv/x/y/epa=%h, expected %h", i, {r_inv, r_x, r_y, r_epa}, ex[i]);
      end
    end
    write_cfg(3'd3, 3'd1, 1'b1, 16'h2000);
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, acc_stall = 0, ready_hi = 0, held_bad = 0;
    logic [3:0]  rx_tag [4];
    logic [27:0] rx_epa [4];
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      yumi_i  = (cyc >= 5);
      v_i     = (sent < 4);
      eva_i   = 32'h4000_0000 | (32'(sent + 1) << 2);
      tag_i   = 4'(sent + 1);
      tgo_x_i = '0; tgo_y_i = '0;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        if (ready_o) ready_hi++;
        if (!(v_o === 1'b1 && tag_o === 4'd1 && epa_o === 28'd1)) held_bad++;
      end
      if (v_o && yumi_i && got < 4) begin
        rx_tag[got] = tag_o; rx_epa[got] = epa_o; got++;
      end
      if (v_i && ready_o) begin
        sent++;
        if (cyc < 5) acc_stall++;
      end
    end
    v_i = 1'b0; yumi_i = 1'b1;
    tests_run++;
    if (acc_stall != 2 || ready_hi != 0) begin
      tests_failed++;
      $display("FAIL b2b_stall_accepts: got accepts=%0d ready_high_cycles=%0d, expected 2 and 0", acc_stall, ready_hi);
    end
    tests_run++;
    if (held_bad != 0) begin
      tests_failed++;
      $display("FAIL b2b_hold: got %0d unstable stall cycles, expected 0", held_bad);
    end
    tests_run++;
    if (got != 4) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d responses, expected 4", got);
    end
    for (int i = 0; i < got; i++) begin
      tests_run++;
      if (rx_tag[i] !== 4'(i + 1) || rx_epa[i] !== 28'(i + 1)) begin
        tests_failed++;
        $display("FAIL b2b_order[%0d]: got tag=%0d epa=%h, expected tag=%0d epa=%0h", i, rx_tag[i], rx_epa[i], i + 1, i + 1);
      end
    end
  endtask

  task automatic test_invalid();
    for (int i = 0; i < 3; i++) begin
      xact(32'h0000_0100, 4'(i + 12), 6'd4, 6'd4);
      tests_run++;
      if ({r_inv, r_x, r_y, r_epa} !== {1'b1, 6'd0, 6'd0, 28'h0} || r_lat != 2) begin
        tests_failed++;
        $display("FAIL invalid[%0d]: got inv/x/y/epa=%0d/%0d/%0d/%h lat=%0d, expected 1/0/0/0 lat=2",
                 i, r_inv, r_x, r_y, r_epa, r_lat);
      end
    end
    @(negedge clk);
    tests_run++;
    if (invalid_count_o !== 16'd3) begin
      tests_failed++;
      $display("FAIL invalid_count: got %0d, expected 3", invalid_count_o);
    end
  endtask

  task automatic test_cfg_block();
    int blocked = 0;
    @(negedge clk);
    v_i = 1'b1; eva_i = 32'h0800_0014; tag_i = 4'd6; tgo_x_i = '0; tgo_y_i = '0; yumi_i = 1'b0;
    cfg_v_i = 1'b1; cfg_lg_tg_x_i = 3'd3; cfg_lg_tg_y_i = 3'd1; cfg_dram_enable_i = 1'b1;
    cfg_dmem_base_i = 16'h0100;
    #1 if (cfg_ready_o === 1'b0) blocked++;
    @(negedge clk);
    v_i = 1'b0;
    #1 if (cfg_ready_o === 1'b0) blocked++;
    @(negedge clk);
    if (cfg_ready_o === 1'b0) blocked++;
    tests_run++;
    if (blocked != 3) begin
      tests_failed++;
      $display("FAIL cfg_blocked: got %0d of 3 cycles with cfg_ready_o=0, expected 3", blocked);
    end
    tests_run++;
    if (v_o !== 1'b1 || epa_o !== 28'h2000 || x_cord_o !== 6'd5 || y_cord_o !== 6'd0) begin
      tests_failed++;
      $display("FAIL cfg_block_resp: got v=%0d x=%0d y=%0d epa=%h, expected 1 5 0 2000", v_o, x_cord_o, y_cord_o, epa_o);
    end
    cfg_v_i = 1'b0; yumi_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if (v_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL cfg_drain: got v_o=%0d cfg_ready=%0d, expected 0 1", v_o, cfg_ready_o);
    end
    xact(32'h0800_0014, 4'd8, 6'd0, 6'd0);
    tests_run++;
    if (r_epa !== 28'h2000) begin
      tests_failed++;
      $display("FAIL cfg_not_applied: got epa=%h, expected 2000", r_epa);
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    @(negedge clk);
    v_i = 1'b1; eva_i = 32'h4404_0010; tag_i = 4'd15; yumi_i = 1'b0;
    @(negedge clk);
    v_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    tests_run++;
    if (v_o !== 1'b0 || epa_o !== 28'h0 || tag_o !== 4'd0 || invalid_count_o !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: got v=%0d epa=%h tag=%0d cnt=%0d, expected 0 0 0 0", v_o, epa_o, tag_o, invalid_count_o);
    end
    @(negedge clk);
    reset_i = 1'b0; yumi_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (v_o) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_flush: got %0d responses after reset, expected 0", seen);
    end
    xact(32'h0800_0014, 4'd1, 6'd0, 6'd1);
    tests_run++;
    if ({r_inv, r_x, r_y, r_epa} !== {1'b0, 6'd1, 6'd2, 28'h400}) begin
      tests_failed++;
      $display("FAIL reset_mid_cfg: got inv/x/y/epa=%0d/%0d/%0d/%h, expected 0/1/2/400", r_inv, r_x, r_y, r_epa);
    end
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; eva_i = '0; tag_i = '0; tgo_x_i = '0; tgo_y_i = '0;
    cfg_v_i = 1'b0; cfg_lg_tg_x_i = '0; cfg_lg_tg_y_i = '0; cfg_dram_enable_i = 1'b0;
    cfg_dmem_base_i = '0; yumi_i = 1'b0;
    test_reset();
    test_global();
    test_tg();
    test_shared_default();
    test_dram_striped();
    test_shared_cfg();
    test_dram_block();
    test_back_to_back();
    test_invalid();
    test_cfg_block();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
